// File: rtl/ripple_carry_adder.sv
// Ripple-carry adder: width-bit sum of a_i + b_i + cin_i, carry out on cout_o.
module ripple_carry_adder #(
    parameter int width = 8
) (
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    input  logic             cin_i,
    output logic [width-1:0] sum_o,
    output logic             cout_o
);

    // Carry ripples LSB to MSB through a single running carry bit.
    always_comb begin
        logic c;
        c     = cin_i;
        sum_o = '0;
        for (int i = 0; i < width; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c;
            c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
        cout_o = c;
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier, one partial product per clock.
// IDLE -> CALC (WIDTH iterations) -> DONE (1-cycle done pulse) -> IDLE.
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Counter holds 0..WIDTH-1 during CALC; sized so it can never wrap early.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]         state_q,   state_d;
    logic [WIDTH-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0]   mplier_q,  mplier_d;
    logic [WIDTH-1:0]   acc_q,     acc_d;
    logic [CW-1:0]      count_q,   count_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cout;

    // Partial product is the multiplicand gated by the current multiplier LSB.
    assign addend = mplier_q[0] ? mcand_q : '0;

    ripple_carry_adder #(.width(WIDTH)) u_adder (
        .a_i    (acc_q),
        .b_i    (addend),
        .cin_i  (1'b0),
        .sum_o  (sum),
        .cout_o (cout)
    );

    // Next-state and datapath update; {cout,sum,mplier} is shifted right by one,
    // so the adder carry lands in the top bit of the accumulator.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = {cout, sum[WIDTH-1:1]};
                mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
                count_d  = count_q + 1'b1;
                if (count_q == LAST) begin
                    product_d = {acc_d, mplier_d};
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status decode straight from the state register.
    always_comb begin
        busy    = (state_q == CALC);
        done    = (state_q == DONE);
        product = product_q;
    end

    // All state, with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: table-driven vectors through a scoreboard,
// plus hand sequences for held start, mid-operation reset and WIDTH=4.
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a, b;
    logic        busy, done;
    logic [15:0] product;

    logic        start4;
    logic [3:0]  a4, b4;
    logic        busy4, done4;
    logic [7:0]  product4;

    int checks   = 0;
    int failures = 0;
    logic [15:0] sb_q[$];
    logic [15:0] last_prod;

    typedef struct {
        logic [7:0]  va;
        logic [7:0]  vb;
        logic [15:0] exp;
        string       nm;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    shift_add_multiplier #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product)
    );

    shift_add_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .product(product4)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: each done pulse consumes one expected product.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                logic [15:0] e;
                e = sb_q.pop_front();
                if (product !== e) begin
                    failures++;
                    $display("FAIL product: got %h expected %h", product, e);
                end
            end
        end
    end

    // One operation on the 8-bit DUT with full latency and hold checks.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic [15:0] exp,
                          input string nm);
        @(negedge clk);
        a = ta; b = tb; start = 1'b1;
        @(posedge clk);
        sb_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        check({nm, "_busy_after_accept"}, 32'(busy), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k < 8) begin
                if (busy !== 1'b1 || done !== 1'b0 || product !== last_prod)
                    check({nm, "_calc"}, {15'd0, busy, done, product}, {15'd0, 1'b1, 1'b0, last_prod});
            end else begin
                check({nm, "_done_timing"}, {30'd0, busy, done}, {30'd0, 1'b0, 1'b1});
            end
        end
        last_prod = exp;
        @(posedge clk);
        @(negedge clk);
        check({nm, "_back_idle"}, {14'd0, busy, done, product}, {14'd0, 1'b0, 1'b0, exp});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'd13,  8'd11,  16'h008F, "13x11"};
        vecs[1] = '{8'hFF,  8'hFF,  16'hFE01, "ffxff"};
        vecs[2] = '{8'h00,  8'h5A,  16'h0000, "0x5a"};
        vecs[3] = '{8'h5A,  8'h00,  16'h0000, "5ax0"};
        vecs[4] = '{8'h01,  8'hFF,  16'h00FF, "1xff"};
        vecs[5] = '{8'h80,  8'h02,  16'h0100, "80x2"};

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        last_prod = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", {14'd0, busy, done, product}, 32'd0);
        check("reset_state4", {22'd0, busy4, done4, product4}, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i].va, vecs[i].vb, vecs[i].exp, vecs[i].nm);

        // Start held high; operands toggled during CALC must not be re-captured.
        @(negedge clk);
        a = 8'd7; b = 8'd6; start = 1'b1;
        @(posedge clk);
        sb_q.push_back(16'd42);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            a = 8'($urandom); b = 8'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        check("held_done", 32'(done), 32'd1);
        a = 8'd9; b = 8'd9;
        @(posedge clk);
        @(negedge clk);
        check("held_idle_not_accepted", {30'd0, busy, done}, 32'd0);
        @(posedge clk);
        sb_q.push_back(16'd81);
        @(negedge clk);
        check("held_second_accept", 32'(busy), 32'd1);
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("held_second_idle", {14'd0, busy, done, product}, {14'd0, 2'b00, 16'd81});
        last_prod = 16'd81;

        // Reset after 4 iterations of 200*200: aborted, no done, product cleared.
        @(negedge clk);
        a = 8'd200; b = 8'd200; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_reset", {14'd0, busy, done, product}, 32'd0);
        last_prod = '0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0)
                check("post_reset_quiet", {30'd0, busy, done}, 32'd0);
        end
        check("post_reset_product", 32'(product), 32'd0);
        run_op(8'd3, 8'd5, 16'd15, "3x5");

        // WIDTH=4 instance: 15*15, done after 4 CALC edges.
        @(negedge clk);
        a4 = 4'd15; b4 = 4'd15; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k < 4) begin
                if (busy4 !== 1'b1 || done4 !== 1'b0)
                    check("w4_calc", {30'd0, busy4, done4}, 32'd2);
            end else begin
                check("w4_done", {22'd0, busy4, done4, product4}, {22'd0, 2'b01, 8'hE1});
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("w4_idle", {22'd0, busy4, done4, product4}, {22'd0, 2'b00, 8'hE1});

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
